// File: rtl/rfs_wifi_sampler_pkg.sv
// Shared register-map constants for the RFS tick sampler: word addresses and
// STATUS/CONTROL bit positions.
package rfs_wifi_sampler_pkg;
   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_DATA    = 3'd2;
   localparam logic [2:0] ADDR_TSTAMP  = 3'd3;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_LEVEL_LSB = 8;

   localparam int CTL_EN      = 0;
   localparam int CTL_IE      = 1;
   localparam int CTL_FLUSH   = 2;
   localparam int CTL_THR_LSB = 8;
endpackage

// File: rtl/rfs_wifi_sampler_fifo.sv
// Show-ahead synchronous FIFO; an extra pointer bit distinguishes full from empty.
// Flush clears both pointers and wins over any same-cycle push or pop.
module rfs_wifi_sampler_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_push, do_pop;

   // A push into a full FIFO is only accepted when the head leaves in the same cycle
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign level = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/rfs_wifi_tick_sampler.sv
// Timer-tick driven sensor sampler with an Avalon-MM drain port and level/overflow irq.
// Define SAMPLER_TIMESTAMP_EN to store a tick-count stamp with every sample.
module rfs_wifi_tick_sampler
   import rfs_wifi_sampler_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick,
   input  logic [DATA_W-1:0] sensor_data,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              read_n,
   input  logic              write_n,
   input  logic [15:0]       writedata,
   output logic [15:0]       readdata,
   output logic              irq
);
   localparam int LW = $clog2(DEPTH) + 1;
`ifdef SAMPLER_TIMESTAMP_EN
   localparam int FW = DATA_W + TS_W;
`else
   localparam int FW = DATA_W;
`endif

   logic              tick_q, tick_edge;
   logic              en, ie, ovf;
   logic [7:0]        thr, thr_eff, level8;
   logic              rd_acc, wr_acc, push, pop, flush, ovf_set;
   logic [FW-1:0]     fifo_wdata, fifo_rdata;
   logic [LW-1:0]     level;
   logic              full, empty;
   logic [DATA_W-1:0] head_data;
   logic [TS_W-1:0]   head_stamp;
   logic [15:0]       rd_mux;
   logic              unused_wd;

   function automatic logic [15:0] zext_data(input logic [DATA_W-1:0] d);
      return 16'(d);
   endfunction

   function automatic logic [15:0] zext_stamp(input logic [TS_W-1:0] s);
      return 16'(s);
   endfunction

   assign rd_acc    = chipselect & ~read_n;
   assign wr_acc    = chipselect & ~write_n;
   assign tick_edge = tick & ~tick_q;
   assign push      = tick_edge & en;
   assign pop       = rd_acc & (address == ADDR_DATA) & ~empty;
   assign flush     = wr_acc & (address == ADDR_CONTROL) & writedata[CTL_FLUSH];
   // A flushed sample is not a lost sample, so it never raises ovf
   assign ovf_set   = push & full & ~pop & ~flush;
   assign unused_wd = ^writedata[7:3];

`ifdef SAMPLER_TIMESTAMP_EN
   logic [TS_W-1:0] tick_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       tick_cnt <= '0;
      else if (tick_edge) tick_cnt <= tick_cnt + 1'b1;
   end

   assign fifo_wdata = {tick_cnt, sensor_data};
   assign head_data  = fifo_rdata[DATA_W-1:0];
   assign head_stamp = fifo_rdata[FW-1:DATA_W];
`else
   assign fifo_wdata = sensor_data;
   assign head_data  = fifo_rdata;
   assign head_stamp = '0;
`endif

   rfs_wifi_sampler_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wdata   (fifo_wdata),
      .rdata   (fifo_rdata),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_q <= 1'b0;
         en     <= 1'b0;
         ie     <= 1'b0;
         thr    <= '0;
         ovf    <= 1'b0;
      end else begin
         tick_q <= tick;
         if (wr_acc && address == ADDR_CONTROL) begin
            en  <= writedata[CTL_EN];
            ie  <= writedata[CTL_IE];
            thr <= writedata[CTL_THR_LSB +: 8];
         end
         if (ovf_set)                                ovf <= 1'b1;
         else if (wr_acc && address == ADDR_STATUS)  ovf <= 1'b0;
      end
   end

   assign level8 = 8'(level);

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_STATUS: begin
            rd_mux[ST_EMPTY]           = empty;
            rd_mux[ST_FULL]            = full;
            rd_mux[ST_OVF]             = ovf;
            rd_mux[ST_LEVEL_LSB +: 8]  = level8;
         end
         ADDR_CONTROL: begin
            rd_mux[CTL_EN]             = en;
            rd_mux[CTL_IE]             = ie;
            rd_mux[CTL_THR_LSB +: 8]   = thr;
         end
         ADDR_DATA:   if (!empty) rd_mux = zext_data(head_data);
         ADDR_TSTAMP: rd_mux = zext_stamp(head_stamp);
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    readdata <= '0;
      else if (rd_acc) readdata <= rd_mux;
   end

   // thr=0 behaves as 1 so "interrupt on any data" needs no special setting
   assign thr_eff = (thr == 8'd0) ? 8'd1 : thr;
   assign irq     = ie & ((level8 >= thr_eff) | ovf);
endmodule

// File: tb/tb_rfs_wifi_tick_sampler.sv
// Self-checking bench for rfs_wifi_tick_sampler: register-map vector table plus
// scoreboard-driven sequences for capture, threshold, overflow, flush and reset.
module tb_rfs_wifi_tick_sampler;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick = 1'b0;
   logic [15:0] sensor_data = '0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;
   logic        irq;

   int n_chk = 0;
   int n_fail = 0;

   // scoreboard / model state
   int   m_q[$];
   bit   m_ovf = 0, m_en = 0, m_ie = 0;
   int   m_thr = 0;

   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[$];

   rfs_wifi_tick_sampler #(.DATA_W(16), .DEPTH(DEPTH), .TS_W(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .sensor_data (sensor_data),
      .address     (address),
      .chipselect  (chipselect),
      .read_n      (read_n),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1; write_n = 0; address = a; writedata = d;
      cyc();
      chipselect = 0; write_n = 1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
      chipselect = 1; read_n = 0; address = a;
      cyc();
      chipselect = 0; read_n = 1;
      d = readdata;
   endtask

   task automatic write_ctrl(input logic [15:0] v);
      m_en = v[0]; m_ie = v[1]; m_thr = int'(v[15:8]);
      if (v[2]) m_q.delete();
      bus_write(3'd1, v);
   endtask

   task automatic model_push(input int d);
      if (m_en) begin
         if (m_q.size() < DEPTH) m_q.push_back(d);
         else m_ovf = 1;
      end
   endtask

   task automatic tick_edge(input logic [15:0] d);
      sensor_data = d; tick = 1;
      model_push(int'(d));
      cyc();
      tick = 0;
      cyc();
   endtask

   function automatic logic [15:0] exp_status();
      int n;
      n = m_q.size();
      return 16'((n << 8) | (int'(m_ovf) << 2) | (int'(n == DEPTH) << 1) | int'(n == 0));
   endfunction

   function automatic logic exp_irq();
      int t;
      t = (m_thr == 0) ? 1 : m_thr;
      return m_ie & ((m_q.size() >= t) | m_ovf);
   endfunction

   task automatic chk_status(input string nm);
      logic [15:0] v;
      logic [15:0] e;
      e = exp_status();
      bus_read(3'd0, v);
      check({nm, "_status"}, v, e);
      check({nm, "_irq"}, 16'(irq), 16'(exp_irq()));
   endtask

   task automatic read_data_chk(input string nm);
      logic [15:0] v;
      logic [15:0] e;
      e = (m_q.size() == 0) ? 16'h0 : 16'(m_q.pop_front());
      bus_read(3'd2, v);
      check(nm, v, e);
   endtask

   initial begin
      logic [15:0] v;

      vecs.push_back('{1'b0, 3'd0, 16'h0000, 16'h0001, "rst_status"});
      vecs.push_back('{1'b0, 3'd1, 16'h0000, 16'h0000, "rst_control"});
      vecs.push_back('{1'b1, 3'd1, 16'hA5F7, 16'h0000, ""});
      vecs.push_back('{1'b0, 3'd1, 16'h0000, 16'hA503, "ctrl_readback"});
      vecs.push_back('{1'b1, 3'd5, 16'hFFFF, 16'h0000, ""});
      vecs.push_back('{1'b0, 3'd5, 16'h0000, 16'h0000, "addr5_zero"});
      vecs.push_back('{1'b0, 3'd7, 16'h0000, 16'h0000, "addr7_zero"});
      vecs.push_back('{1'b0, 3'd2, 16'h0000, 16'h0000, "data_empty"});
      vecs.push_back('{1'b1, 3'd1, 16'h0000, 16'h0000, ""});
      vecs.push_back('{1'b0, 3'd1, 16'h0000, 16'h0000, "ctrl_cleared"});

      repeat (3) cyc();
      check("rst_readdata", readdata, 16'h0);
      check("rst_irq", 16'(irq), 16'h0);
      reset_n = 1;
      cyc();

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            if (vecs[i].addr == 3'd1) write_ctrl(vecs[i].wdata);
            else bus_write(vecs[i].addr, vecs[i].wdata);
         end else begin
            bus_read(vecs[i].addr, v);
            check(vecs[i].name, v, vecs[i].exp);
         end
      end

      // single capture, thr=0
      write_ctrl(16'h0003);
      tick_edge(16'h1234);
      chk_status("t1_after_tick");
      read_data_chk("t1_data");
      chk_status("t1_drained");

      // threshold 4
      write_ctrl(16'h0403);
      for (int i = 1; i <= 4; i++) begin
         tick_edge(16'(i));
         check($sformatf("t2_irq_%0d", i), 16'(irq), 16'(exp_irq()));
      end
      for (int i = 1; i <= 4; i++) read_data_chk($sformatf("t2_data_%0d", i));

      // overflow
      write_ctrl(16'h0003);
      for (int i = 1; i <= 17; i++) tick_edge(16'(i));
      chk_status("t3_full_ovf");
      for (int i = 1; i <= 16; i++) read_data_chk($sformatf("t3_data_%0d", i));
      bus_write(3'd0, 16'h0000);
      m_ovf = 0;
      chk_status("t3_ovf_clr");

      // simultaneous push and pop while full
      for (int i = 0; i < 16; i++) tick_edge(16'(16'h100 + i));
      sensor_data = 16'h02FF; tick = 1;
      chipselect = 1; read_n = 0; address = 3'd2;
      cyc();
      tick = 0; chipselect = 0; read_n = 1;
      check("t4_popped_head", readdata, 16'(m_q.pop_front()));
      m_q.push_back(16'h02FF);
      cyc();
      chk_status("t4_full_no_ovf");
      for (int i = 0; i < 16; i++) read_data_chk($sformatf("t4_data_%0d", i));

      // en=0 ignores edges
      write_ctrl(16'h0002);
      for (int i = 0; i < 3; i++) tick_edge(16'(16'h0AA0 + i));
      chk_status("t5_en0");

      // flush against a push into a full FIFO
      write_ctrl(16'h0003);
      for (int i = 0; i < 16; i++) tick_edge(16'(16'h0300 + i));
      sensor_data = 16'h0BAD; tick = 1;
      chipselect = 1; write_n = 0; address = 3'd1; writedata = 16'h0007;
      m_q.delete(); m_en = 1; m_ie = 1; m_thr = 0;
      cyc();
      tick = 0; chipselect = 0; write_n = 1;
      cyc();
      chk_status("t5_flush");

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) tick_edge(16'(16'h0400 + i));
      bus_read(3'd0, v);
      check("t5_pre_rst_status", v, exp_status());
      check("t5_pre_rst_irq", 16'(irq), 16'h1);
      #2 reset_n = 0;
      #1;
      check("t5_async_readdata", readdata, 16'h0);
      check("t5_async_irq", 16'(irq), 16'h0);
      m_q.delete(); m_ovf = 0; m_en = 0; m_ie = 0; m_thr = 0;
      cyc();
      reset_n = 1;
      cyc();
      chk_status("t5_post_rst");
      bus_read(3'd1, v);
      check("t5_post_rst_ctrl", v, 16'h0);

`ifdef SAMPLER_TIMESTAMP_EN
      write_ctrl(16'h0000);
      tick_edge(16'h0011);
      write_ctrl(16'h0001);
      tick_edge(16'h0022);
      tick_edge(16'h0033);
      bus_read(3'd3, v);
      check("t6_stamp_1", v, 16'd1);
      read_data_chk("t6_data_s2");
      bus_read(3'd3, v);
      check("t6_stamp_2", v, 16'd2);
      read_data_chk("t6_data_s3");
`else
      write_ctrl(16'h0001);
      tick_edge(16'h0055);
      bus_read(3'd3, v);
      check("t6_tstamp_zero", v, 16'h0);
      read_data_chk("t6_data");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
